// File: rtl/btn_arb_pkg.sv
// Shared types and helpers for the button event arbiter and its round-robin picker.
package btn_arb_pkg;

  localparam int NUM_BTN_DEF    = 4;
  localparam int DROP_CNT_W_DEF = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } fsm_state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_event_arbiter_rr_pick.sv
// Combinational round-robin search: first set request strictly after 'last', wrapping.
module rr_pick
  import btn_arb_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEF,
  parameter int IDW     = clog2_min1(NUM_BTN_DEF)
) (
  input  logic [NUM_BTN-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic               gnt_valid,
  output logic [IDW-1:0]     gnt_idx
);

  logic [IDW-1:0] w_idx;

  // Walk from the farthest candidate back to the nearest so the nearest hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_idx     = '0;
    for (int k = NUM_BTN; k >= 1; k--) begin
      w_idx = IDW'((int'(last) + k) % NUM_BTN);
      if (req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Latches debounced button pulses and serialises them round-robin over valid/ready.
// Define BTN_DROP_CNT_EN to add saturating per-channel drop counters on drop_cnt.
module btn_event_arbiter
  import btn_arb_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEF
`ifdef BTN_DROP_CNT_EN
  ,
  parameter int DROP_CNT_W = DROP_CNT_W_DEF
`endif
) (
  input  logic                             sysclk,
  input  logic                             reset,
  input  logic [NUM_BTN-1:0]               btn_pulse,
  output logic                             evt_valid,
  input  logic                             evt_ready,
  output logic [clog2_min1(NUM_BTN)-1:0]   evt_id,
  output logic [NUM_BTN-1:0]               pending,
  output logic [NUM_BTN-1:0]               overflow,
  input  logic                             clr_overflow
`ifdef BTN_DROP_CNT_EN
  ,
  output logic [NUM_BTN*DROP_CNT_W-1:0]    drop_cnt
`endif
);

  localparam int IDW = clog2_min1(NUM_BTN);

  fsm_state_t         r_state, w_state_next;
  logic [NUM_BTN-1:0] r_pending, w_pending_next;
  logic [NUM_BTN-1:0] r_overflow, w_overflow_next;
  logic [IDW-1:0]     r_evt_id, w_evt_id_next;
  logic               r_evt_valid, w_evt_valid_next;
  logic [IDW-1:0]     r_last, w_last_next;

  logic               w_gnt_valid;
  logic [IDW-1:0]     w_gnt_idx;
  logic               w_grant;
  logic [NUM_BTN-1:0] w_gnt_mask;
  logic [NUM_BTN-1:0] w_ovf_evt;

  rr_pick #(
    .NUM_BTN (NUM_BTN),
    .IDW     (IDW)
  ) u_rr_pick (
    .req       (r_pending),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  always_comb begin
    w_state_next     = r_state;
    w_grant          = 1'b0;
    w_evt_valid_next = r_evt_valid;
    w_evt_id_next    = r_evt_id;
    w_last_next      = r_last;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_grant          = 1'b1;
          w_evt_valid_next = 1'b1;
          w_evt_id_next    = w_gnt_idx;
          w_last_next      = w_gnt_idx;
          w_state_next     = PRESENT;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          w_evt_valid_next = 1'b0;
          w_state_next     = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A press on the channel being granted re-arms it instead of counting as a drop.
  always_comb begin
    w_gnt_mask      = w_grant ? (NUM_BTN'(1) << w_gnt_idx) : '0;
    w_ovf_evt       = btn_pulse & r_pending & ~w_gnt_mask;
    w_pending_next  = (r_pending & ~w_gnt_mask) | btn_pulse;
    w_overflow_next = (clr_overflow ? '0 : r_overflow) | w_ovf_evt;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_overflow  <= '0;
      r_evt_id    <= '0;
      r_evt_valid <= 1'b0;
      r_last      <= IDW'(NUM_BTN - 1);
    end else begin
      r_state     <= w_state_next;
      r_pending   <= w_pending_next;
      r_overflow  <= w_overflow_next;
      r_evt_id    <= w_evt_id_next;
      r_evt_valid <= w_evt_valid_next;
      r_last      <= w_last_next;
    end
  end

`ifdef BTN_DROP_CNT_EN
  localparam logic [DROP_CNT_W-1:0] CNT_MAX = '1;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_drop_cnt
      logic [DROP_CNT_W-1:0] r_cnt;

      // Clear and a same-cycle drop together leave a count of one.
      always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_ovf_evt[gi]) begin
          if (clr_overflow) begin
            r_cnt <= DROP_CNT_W'(1);
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + DROP_CNT_W'(1);
          end
        end else if (clr_overflow) begin
          r_cnt <= '0;
        end
      end

      assign drop_cnt[gi*DROP_CNT_W +: DROP_CNT_W] = r_cnt;
    end
  endgenerate
`endif

  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed self-checking bench for btn_event_arbiter (default 4 channels).
module tb_btn_event_arbiter;

  localparam int NB = 4;

  logic          sysclk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_pulse = '0;
  logic          evt_ready = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          evt_valid;
  logic [1:0]    evt_id;
  logic [NB-1:0] pending;
  logic [NB-1:0] overflow;
`ifdef BTN_DROP_CNT_EN
  logic [NB*8-1:0] drop_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  btn_event_arbiter dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .btn_pulse    (btn_pulse),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_id       (evt_id),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef BTN_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (!reset && evt_valid && evt_ready)
      $display("evt accepted id=%0d t=%0t", evt_id, $time);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_pulse = '0;
    evt_ready = 1'b0;
    clr_overflow = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic expect_grant(input string tag, input logic [1:0] id);
    check({tag, "_valid"}, 32'(evt_valid), 32'd1);
    check({tag, "_id"}, 32'(evt_id), 32'(id));
  endtask

  initial begin
    // 1: reset state and single-event latency
    step();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_id", 32'(evt_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef BTN_DROP_CNT_EN
    check("rst_drop", drop_cnt, 32'd0);
`endif
    do_reset();
    btn_pulse = 4'b0001;
    evt_ready = 1'b1;
    step();
    btn_pulse = '0;
    check("t1_pend", 32'(pending), 32'b0001);
    check("t1_valid_c1", 32'(evt_valid), 32'd0);
    step();
    expect_grant("t1_c2", 2'd0);
    check("t1_pend_clr", 32'(pending), 32'd0);
    step();
    check("t1_valid_c3", 32'(evt_valid), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);

    // 2: three pending events drain in order 0,1,3, one per two cycles
    do_reset();
    evt_ready = 1'b1;
    btn_pulse = 4'b1011;
    step();
    btn_pulse = '0;
    check("t2_pend", 32'(pending), 32'b1011);
    step();
    expect_grant("t2_g0", 2'd0);
    step();
    check("t2_gap0", 32'(evt_valid), 32'd0);
    step();
    expect_grant("t2_g1", 2'd1);
    step();
    check("t2_gap1", 32'(evt_valid), 32'd0);
    step();
    expect_grant("t2_g3", 2'd3);
    check("t2_drained", 32'(pending), 32'd0);
    step();
    check("t2_ovf", 32'(overflow), 32'd0);

    // 3: ch1 hammering cannot starve ch2
    do_reset();
    evt_ready = 1'b1;
    btn_pulse = 4'b0111;
    step();
    btn_pulse = 4'b0010;
    step();
    expect_grant("t3_g0", 2'd0);
    step();
    step();
    expect_grant("t3_g1", 2'd1);
    step();
    step();
    expect_grant("t3_g2", 2'd2);
    step();
    step();
    expect_grant("t3_g1b", 2'd1);
    check("t3_ovf", 32'(overflow), 32'b0010);
    btn_pulse = '0;

    // 4: stalled consumer holds id 2; a new ch2 press re-pends without overflow
    do_reset();
    btn_pulse = 4'b0100;
    step();
    btn_pulse = '0;
    step();
    expect_grant("t4_start", 2'd2);
    for (int i = 0; i < 10; i++) begin
      btn_pulse = (i == 3) ? 4'b0100 : 4'b0000;
      step();
      expect_grant($sformatf("t4_hold%0d", i), 2'd2);
    end
    btn_pulse = '0;
    check("t4_pend", 32'(pending), 32'b0100);
    check("t4_ovf", 32'(overflow), 32'd0);

    // 5: drops on ch1 while stalled, then clear racing a drop
    btn_pulse = 4'b0010;
    step();
    check("t5_pend", 32'(pending), 32'b0110);
    check("t5_noovf", 32'(overflow), 32'd0);
    step();
    step();
    btn_pulse = '0;
    check("t5_ovf", 32'(overflow), 32'b0010);
`ifdef BTN_DROP_CNT_EN
    check("t5_drop2", 32'(drop_cnt[8 +: 8]), 32'd2);
`endif
    clr_overflow = 1'b1;
    btn_pulse = 4'b0010;
    step();
    btn_pulse = '0;
    check("t5_clr_race", 32'(overflow), 32'b0010);
`ifdef BTN_DROP_CNT_EN
    check("t5_drop1", 32'(drop_cnt[8 +: 8]), 32'd1);
`endif
    step();
    clr_overflow = 1'b0;
    check("t5_clr", 32'(overflow), 32'd0);
`ifdef BTN_DROP_CNT_EN
    check("t5_drop0", 32'(drop_cnt[8 +: 8]), 32'd0);
`endif
    expect_grant("t5_still", 2'd2);

    // 6: reset mid-handshake drops everything at once
    btn_pulse = 4'b1000;
    step();
    btn_pulse = '0;
    check("t6_pend", 32'(pending), 32'b1110);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(evt_valid), 32'd0);
    check("t6_async_pend", 32'(pending), 32'd0);
    step();
    reset = 1'b0;
    check("t6_id", 32'(evt_id), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    evt_ready = 1'b1;
    btn_pulse = 4'b1101;
    step();
    btn_pulse = '0;
    step();
    expect_grant("t6_first", 2'd0);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
